// File: rtl/step_seq_gen.sv
// ---------------------------------------------------------------------------
// step_seq_gen
// Symbol-sequence generator that feeds a downstream step FSM. A command
// handshake selects one of two three-phase sequences (S1 = 1,2,3 or
// S2 = 4,5,6) and a repeat count. The selected sequence is emitted back to
// back the requested number of times, with no idle symbol between repeats.
// The value 7 is never driven.
//
// Optional feature macro: STEP_SEQ_GEN_HAMMING_EN
//   When defined, the phase and selector word is stored as a Hamming(7,4)
//   codeword. It is corrected by h3_correct_n_k before it is decoded, and
//   sec_o reports each single-bit correction. When undefined, the word is
//   stored in plain binary and sec_o is tied to 0.
//
// Parameters:
//   IO_SIZE_G   symbol width (only 3 is meaningful)
//   CNT_W_G     width of the repeat count
// Ports:
//   clk_i        clock, rising edge
//   rst_n_i      synchronous active-low reset
//   cmd_valid_i  command request
//   cmd_ready_o  command accept (IDLE, out of reset, abort low)
//   cmd_sel_i    sequence select, 0 = S1, 1 = S2
//   cmd_count_i  number of back-to-back sequences
//   abort_i      synchronous abort, highest priority after reset
//   data_o       registered symbol stream
//   busy_o       registered, high while not in IDLE
//   done_o       registered one-cycle completion pulse
//   remaining_o  registered count of sequences left, including the current one
//   sec_o        registered single-error-corrected flag
// ---------------------------------------------------------------------------

`ifdef STEP_SEQ_GEN_HAMMING_EN
// Hamming(7,4) single-error corrector. Codeword bit i holds position i+1:
// positions 1,2,4 are parity and positions 3,5,6,7 carry data bits 0..3.
module h3_correct_n_k (
    input  logic [6:0] code_i,
    output logic [3:0] data_o,
    output logic       sec_o
);
    logic [2:0] syndrome;
    logic [6:0] flip;
    logic [6:0] fixed;

    assign syndrome[0] = code_i[0] ^ code_i[2] ^ code_i[4] ^ code_i[6];
    assign syndrome[1] = code_i[1] ^ code_i[2] ^ code_i[5] ^ code_i[6];
    assign syndrome[2] = code_i[3] ^ code_i[4] ^ code_i[5] ^ code_i[6];

    // A nonzero syndrome is the position of the bad bit.
    assign flip   = (syndrome != 3'd0) ? (7'd1 << (syndrome - 3'd1)) : 7'd0;
    assign fixed  = code_i ^ flip;
    assign data_o = {fixed[6], fixed[5], fixed[4], fixed[2]};
    assign sec_o  = (syndrome != 3'd0);
endmodule
`endif

module step_seq_gen #(
    parameter int IO_SIZE_G = 3,
    parameter int CNT_W_G   = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    input  logic                 cmd_valid_i,
    output logic                 cmd_ready_o,
    input  logic                 cmd_sel_i,
    input  logic [CNT_W_G-1:0]   cmd_count_i,
    input  logic                 abort_i,
    output logic [IO_SIZE_G-1:0] data_o,
    output logic                 busy_o,
    output logic                 done_o,
    output logic [CNT_W_G-1:0]   remaining_o,
    output logic                 sec_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PH_A = 2'd1,
        PH_B = 2'd2,
        PH_C = 2'd3
    } phase_t;

    phase_t               cur_ph;
    phase_t               nxt_ph;
    logic                 cur_sel;
    logic                 nxt_sel;
    logic                 cur_legal;
    logic                 cur_sec;
    logic [CNT_W_G-1:0]   nxt_rem;
    logic                 nxt_done;
    logic [IO_SIZE_G-1:0] nxt_data;

`ifdef STEP_SEQ_GEN_HAMMING_EN
    // Stored word is {pad, sel, phase[1:0]} protected as a Hamming(7,4)
    // codeword. A pad bit that is still set after correction means that
    // more than one bit was upset, so the word is treated as unrecoverable.
    logic [6:0] state_q;
    logic [3:0] fixed_word;

    function automatic logic [6:0] ham_encode(input logic [3:0] d);
        logic p1, p2, p3;
        p1 = d[0] ^ d[1] ^ d[3];
        p2 = d[0] ^ d[2] ^ d[3];
        p3 = d[1] ^ d[2] ^ d[3];
        return {d[3], d[2], d[1], p3, d[0], p2, p1};
    endfunction

    h3_correct_n_k u_corr (
        .code_i (state_q),
        .data_o (fixed_word),
        .sec_o  (cur_sec)
    );

    assign cur_ph    = phase_t'(fixed_word[1:0]);
    assign cur_sel   = fixed_word[2];
    assign cur_legal = ~fixed_word[3];
`else
    // Stored word is {sel, phase[1:0]} in plain binary. Every encoding is
    // a valid state, so no decode can be illegal.
    logic [2:0] state_q;

    assign cur_ph    = phase_t'(state_q[1:0]);
    assign cur_sel   = state_q[2];
    assign cur_legal = 1'b1;
    assign cur_sec   = 1'b0;
`endif

    // Ready depends only on the decoded state, abort and reset.
    assign cmd_ready_o = rst_n_i && cur_legal && (cur_ph == IDLE) && !abort_i;

    // Next-state decode. Abort has priority over every transition and never
    // raises done. After the last C phase the block goes to IDLE and pulses
    // done. On earlier C phases it returns straight to A, so no idle symbol
    // appears between repeats.
    always_comb begin
        nxt_ph   = IDLE;
        nxt_sel  = cur_sel;
        nxt_rem  = '0;
        nxt_done = 1'b0;
        if (abort_i) begin
            nxt_ph = IDLE;
        end else if (!cur_legal) begin
            nxt_ph = IDLE;
        end else begin
            case (cur_ph)
                IDLE: begin
                    if (cmd_valid_i && cmd_ready_o) begin
                        if (cmd_count_i != '0) begin
                            nxt_ph  = PH_A;
                            nxt_sel = cmd_sel_i;
                            nxt_rem = cmd_count_i;
                        end else begin
                            nxt_done = 1'b1;
                        end
                    end
                end
                PH_A: begin
                    nxt_ph  = PH_B;
                    nxt_rem = remaining_o;
                end
                PH_B: begin
                    nxt_ph  = PH_C;
                    nxt_rem = remaining_o;
                end
                PH_C: begin
                    if (remaining_o > CNT_W_G'(1)) begin
                        nxt_ph  = PH_A;
                        nxt_rem = remaining_o - CNT_W_G'(1);
                    end else begin
                        nxt_done = 1'b1;
                    end
                end
                default: nxt_ph = IDLE;
            endcase
        end
    end

    // Symbol for the next state. S2 symbols are the S1 symbols offset by 3.
    always_comb begin
        nxt_data = '0;
        if (nxt_ph != IDLE) begin
            if (nxt_sel) begin
                nxt_data = IO_SIZE_G'({1'b0, nxt_ph}) + IO_SIZE_G'(3);
            end else begin
                nxt_data = IO_SIZE_G'({1'b0, nxt_ph});
            end
        end
    end

    // State and every output register. Reset overrides abort and handshakes.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q     <= '0;
            data_o      <= '0;
            busy_o      <= 1'b0;
            done_o      <= 1'b0;
            remaining_o <= '0;
            sec_o       <= 1'b0;
        end else begin
`ifdef STEP_SEQ_GEN_HAMMING_EN
            state_q     <= ham_encode({1'b0, nxt_sel, nxt_ph});
`else
            state_q     <= {nxt_sel, nxt_ph};
`endif
            data_o      <= nxt_data;
            busy_o      <= (nxt_ph != IDLE);
            done_o      <= nxt_done;
            remaining_o <= nxt_rem;
            sec_o       <= cur_sec;
        end
    end

endmodule

// File: tb/tb_step_seq_gen.sv
// ---------------------------------------------------------------------------
// tb_step_seq_gen
// Directed testbench for step_seq_gen. It covers reset, S1 x1, S2 x3, a
// zero count, abort, reset in mid-sequence and a single state-bit upset.
// The upset is corrected when STEP_SEQ_GEN_HAMMING_EN is defined. Without
// the macro, the block recovers to IDLE. Expected values are hand-computed
// constants.
// ---------------------------------------------------------------------------
module tb_step_seq_gen;

    logic       clk;
    logic       rst_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       cmd_sel;
    logic [7:0] cmd_count;
    logic       abort;
    logic [2:0] data;
    logic       busy;
    logic       done;
    logic [7:0] remaining;
    logic       sec;

    int compare_count  = 0;
    int mismatch_count = 0;

    int exp_s1_data [4]  = '{1, 2, 3, 0};
    int exp_s1_done [4]  = '{0, 0, 0, 1};
    int exp_s2_data [10] = '{4, 5, 6, 4, 5, 6, 4, 5, 6, 0};
    int exp_s2_rem  [10] = '{3, 3, 3, 2, 2, 2, 1, 1, 1, 0};
    int exp_s2_done [10] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1};
    int exp_s2_busy [10] = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 0};

    step_seq_gen #(
        .IO_SIZE_G (3),
        .CNT_W_G   (8)
    ) dut (
        .clk_i       (clk),
        .rst_n_i     (rst_n),
        .cmd_valid_i (cmd_valid),
        .cmd_ready_o (cmd_ready),
        .cmd_sel_i   (cmd_sel),
        .cmd_count_i (cmd_count),
        .abort_i     (abort),
        .data_o      (data),
        .busy_o      (busy),
        .done_o      (done),
        .remaining_o (remaining),
        .sec_o       (sec)
    );

    // 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Drives the command and abort inputs.
    task automatic applyStimulus(input logic v, input logic s,
                                 input logic [7:0] c, input logic a);
        cmd_valid = v;
        cmd_sel   = s;
        cmd_count = c;
        abort     = a;
    endtask

    // Counts one comparison and reports it when it mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        compare_count++;
        if (observed !== expected) begin
            mismatch_count++;
            $display("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    // Advances one rising edge and settles 1 ns after it.
    task automatic waitCycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        applyStimulus(1'b0, 1'b0, 8'd0, 1'b0);

        // Reset state.
        waitCycle();
        waitCycle();
        checkOutput("rst_data",  data,      0);
        checkOutput("rst_busy",  busy,      0);
        checkOutput("rst_done",  done,      0);
        checkOutput("rst_rem",   remaining, 0);
        checkOutput("rst_sec",   sec,       0);
        checkOutput("rst_ready", cmd_ready, 0);
        rst_n = 1'b1;
        #1;
        checkOutput("post_rst_ready", cmd_ready, 1);

        // S1 x1.
        applyStimulus(1'b1, 1'b0, 8'd1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            waitCycle();
            applyStimulus(1'b0, 1'b0, 8'd0, 1'b0);
            checkOutput($sformatf("s1_data%0d", i), data, exp_s1_data[i]);
            checkOutput($sformatf("s1_done%0d", i), done, exp_s1_done[i]);
        end
        checkOutput("s1_ready_end", cmd_ready, 1);

        // S2 x3.
        applyStimulus(1'b1, 1'b1, 8'd3, 1'b0);
        for (int i = 0; i < 10; i++) begin
            waitCycle();
            applyStimulus(1'b0, 1'b0, 8'd0, 1'b0);
            checkOutput($sformatf("s2_data%0d", i), data,      exp_s2_data[i]);
            checkOutput($sformatf("s2_rem%0d", i),  remaining, exp_s2_rem[i]);
            checkOutput($sformatf("s2_done%0d", i), done,      exp_s2_done[i]);
            checkOutput($sformatf("s2_busy%0d", i), busy,      exp_s2_busy[i]);
        end
        waitCycle();
        checkOutput("s2_done_clear", done, 0);

        // Zero count.
        applyStimulus(1'b1, 1'b1, 8'd0, 1'b0);
        waitCycle();
        applyStimulus(1'b0, 1'b0, 8'd0, 1'b0);
        checkOutput("z_data", data, 0);
        checkOutput("z_done", done, 1);
        checkOutput("z_busy", busy, 0);
        waitCycle();
        checkOutput("z_done_clear", done, 0);
        checkOutput("z_busy2",      busy, 0);

        // Abort while data is 2.
        applyStimulus(1'b1, 1'b0, 8'd2, 1'b0);
        waitCycle();
        applyStimulus(1'b0, 1'b0, 8'd0, 1'b0);
        checkOutput("ab_data_a", data, 1);
        waitCycle();
        checkOutput("ab_data_b", data,      2);
        checkOutput("ab_rem_b",  remaining, 2);
        applyStimulus(1'b0, 1'b0, 8'd0, 1'b1);
        waitCycle();
        checkOutput("ab_data", data,      0);
        checkOutput("ab_rem",  remaining, 0);
        checkOutput("ab_done", done,      0);
        checkOutput("ab_busy", busy,      0);
        applyStimulus(1'b1, 1'b1, 8'd5, 1'b1);
        #1;
        checkOutput("ab_ready_blocked", cmd_ready, 0);
        waitCycle();
        checkOutput("ab_no_accept_data", data, 0);
        checkOutput("ab_no_accept_busy", busy, 0);
        checkOutput("ab_no_done",        done, 0);
        applyStimulus(1'b0, 1'b0, 8'd0, 1'b0);
        #1;
        checkOutput("ab_ready_back", cmd_ready, 1);
        waitCycle();
        checkOutput("ab_no_done2", done, 0);

        // Reset while data is 5. The held cmd_valid must wait for release.
        applyStimulus(1'b1, 1'b1, 8'd2, 1'b0);
        waitCycle();
        applyStimulus(1'b0, 1'b0, 8'd0, 1'b0);
        waitCycle();
        checkOutput("mr_pre_data", data, 5);
        rst_n = 1'b0;
        applyStimulus(1'b1, 1'b0, 8'd1, 1'b0);
        waitCycle();
        checkOutput("mr_data",  data,      0);
        checkOutput("mr_busy",  busy,      0);
        checkOutput("mr_done",  done,      0);
        checkOutput("mr_rem",   remaining, 0);
        checkOutput("mr_sec",   sec,       0);
        checkOutput("mr_ready", cmd_ready, 0);
        waitCycle();
        checkOutput("mr_hold_data", data, 0);
        checkOutput("mr_hold_done", done, 0);
        rst_n = 1'b1;
        #1;
        checkOutput("mr_ready_rel", cmd_ready, 1);
        waitCycle();
        applyStimulus(1'b0, 1'b0, 8'd0, 1'b0);
        checkOutput("mr_acc_data", data,      1);
        checkOutput("mr_acc_rem",  remaining, 1);
        waitCycle();
        waitCycle();
        checkOutput("mr_data3", data, 3);
        waitCycle();
        checkOutput("mr_end_data", data, 0);
        checkOutput("mr_end_done", done, 1);

        // Single state-bit upset during PH_B of S1.
        waitCycle();
        applyStimulus(1'b1, 1'b0, 8'd1, 1'b0);
        waitCycle();
        applyStimulus(1'b0, 1'b0, 8'd0, 1'b0);
        waitCycle();
        checkOutput("seu_pre_data", data, 2);
`ifdef STEP_SEQ_GEN_HAMMING_EN
        dut.state_q[4] = ~dut.state_q[4];
        waitCycle();
        checkOutput("seu_data3", data, 3);
        checkOutput("seu_sec1",  sec,  1);
        waitCycle();
        checkOutput("seu_data0", data, 0);
        checkOutput("seu_sec0",  sec,  0);
        checkOutput("seu_done",  done, 1);
`else
        dut.state_q[1] = ~dut.state_q[1];
        waitCycle();
        checkOutput("seu_idle_data",  data,      0);
        checkOutput("seu_idle_busy",  busy,      0);
        checkOutput("seu_idle_rem",   remaining, 0);
        checkOutput("seu_idle_ready", cmd_ready, 1);
        checkOutput("seu_sec",        sec,       0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_count, mismatch_count);
        $finish;
    end

endmodule

// File: doc/step_seq_gen.md
STEP_SEQ_GEN -- requirements
Module: step_seq_gen

Interface
REQ-001 The block SHALL have parameter IO_SIZE_G, default 3, sequence symbol width; only 3 is supported.
REQ-002 The block SHALL have parameter CNT_W_G, default 8, width of the repeat count.
REQ-003 The block SHALL have port clk_i, input, 1, the single clock; all logic is on its rising edge.
REQ-004 The block SHALL have port rst_n_i, input, 1, reset; it is synchronous and active-low.
REQ-005 The block SHALL have port cmd_valid_i, input, 1, command request.
REQ-006 The block SHALL have port cmd_ready_o, output, 1, command accept.
REQ-007 The block SHALL have port cmd_sel_i, input, 1, sequence select: 0 = S1, 1 = S2.
REQ-008 The block SHALL have port cmd_count_i, input, CNT_W_G, number of back-to-back sequences.
REQ-009 The block SHALL have port abort_i, input, 1, synchronous abort.
REQ-010 The block SHALL have port data_o, output, IO_SIZE_G, registered symbol stream to the downstream step FSM.
REQ-011 The block SHALL have port busy_o, output, 1, high while not in IDLE.
REQ-012 The block SHALL have port done_o, output, 1, one-cycle completion pulse.
REQ-013 The block SHALL have port remaining_o, output, CNT_W_G, sequences still to be emitted, including the current one.
REQ-014 The block SHALL have port sec_o, output, 1, single-error-corrected flag for the state register.

Function
REQ-015 Symbol encoding SHALL be: IDLE = 0; S1_A/B/C = 1/2/3; S2_A/B/C = 4/5/6; the value 7 SHALL never be driven.
REQ-016 The FSM SHALL have the states IDLE, PH_A, PH_B, PH_C, and a registered selector latched from cmd_sel_i.
REQ-017 cmd_ready_o SHALL be 1 only in IDLE; a handshake occurs when cmd_valid_i and cmd_ready_o are both high.
REQ-018 On a handshake with cmd_count_i greater than 0, the block SHALL go to PH_A; data_o SHALL show the A symbol in the next cycle and remaining_o SHALL equal cmd_count_i.
REQ-019 The phases SHALL advance PH_A -> PH_B -> PH_C, one symbol per cycle, with no stalls.
REQ-020 From PH_C with remaining_o greater than 1, the block SHALL decrement remaining_o and go directly to PH_A; no IDLE symbol is inserted (legal C->A transition).
REQ-021 From PH_C with remaining_o equal to 1, the block SHALL go to IDLE, set remaining_o to 0, and pulse done_o in the cycle where data_o returns to 0.
REQ-022 A handshake with cmd_count_i equal to 0 SHALL stay in IDLE, keep data_o at 0, and pulse done_o in the next cycle.
REQ-023 The block SHALL ignore cmd_sel_i and cmd_count_i outside a handshake.
REQ-024 abort_i SHALL have priority over every transition: the next state is IDLE, data_o = 0, remaining_o = 0, and done_o is not pulsed.
REQ-025 abort_i in IDLE SHALL block any handshake in the same cycle; cmd_ready_o SHALL be forced to 0 while abort_i is high.
REQ-026 An illegal or unrecoverable state encoding SHALL go to IDLE in the next cycle and drive data_o to 0.
REQ-027 data_o, done_o, busy_o and remaining_o SHALL all be register outputs with no combinational path from the inputs; cmd_ready_o SHALL be a decode of the state and abort_i only.

Reset
REQ-028 While rst_n_i is low at a clock edge, the block SHALL set state to IDLE, data_o = 0, busy_o = 0, done_o = 0, remaining_o = 0 and sec_o = 0.
REQ-029 Reset SHALL override abort_i and any handshake; a sequence in progress is truncated with no done_o pulse.
REQ-030 cmd_ready_o SHALL be 0 during reset and 1 in the first cycle after reset is released, provided abort_i is low.

Configuration
REQ-031 With STEP_SEQ_GEN_HAMMING_EN defined, the state and selector (3 bits padded to 4) SHALL be stored as a Hamming(7,4) word.
REQ-032 With STEP_SEQ_GEN_HAMMING_EN defined, that word SHALL be corrected by h3_correct_n_k before the next-state and output decode, and sec_o SHALL be a registered copy of the corrector's sec_o.
REQ-033 Without STEP_SEQ_GEN_HAMMING_EN, the state SHALL use plain binary encoding, sec_o SHALL be tied to 0, and all other behaviour SHALL be identical.

Verification
REQ-034 Test S1 x1: sel=0, count=1 -> data_o 1,2,3,0 in cycles +1..+4; done_o high at +4 only.
REQ-035 Test S2 x3: sel=1, count=3 -> data_o 4,5,6,4,5,6,4,5,6,0; remaining_o 3,3,3,2,2,2,1,1,1,0; one done_o pulse.
REQ-036 Test count=0: handshake -> data_o stays 0, done_o at +1, busy_o stays 0.
REQ-037 Test abort: abort_i raised while data_o=2 -> data_o=0 next cycle, remaining_o=0, no done_o, cmd_ready_o returns once abort_i drops.
REQ-038 Test reset mid-sequence: rst_n_i=0 while data_o=5 -> all outputs at reset values next cycle; cmd_valid_i held high is not accepted until reset is released.
REQ-039 Test SEU, with STEP_SEQ_GEN_HAMMING_EN: flip one state register bit during PH_B of S1 -> data_o sequence 2,3,0 unchanged and sec_o pulses; without the macro, the bench checks recovery to IDLE via REQ-026.
